// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision add controller and its bypass detector.
// No logic; only the field layout, canonical quiet NaN and controller state encoding.
// No handshakes are defined here.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/fp_special_detect.sv
// Classifies an operand pair as NaN/infinite and forms the result that bypasses the adder core.
// Purely combinational, zero latency.
// No handshake; the controller samples the outputs only when it accepts a pair.
module fp_special_detect
  import fp_pkg::*;
(
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        eop,
  output logic        x_nan,
  output logic        y_nan,
  output logic        x_inf,
  output logic        y_inf,
  output logic        is_special,
  output logic [31:0] byp_z,
  output logic        byp_invalid,
  output logic        byp_overflow
);

  logic x_exp_max;
  logic y_exp_max;

  assign x_exp_max  = (x[MAN_W +: EXP_W] == EXP_MAX);
  assign y_exp_max  = (y[MAN_W +: EXP_W] == EXP_MAX);
  assign x_nan      = x_exp_max & (|x[MAN_W-1:0]);
  assign y_nan      = y_exp_max & (|y[MAN_W-1:0]);
  assign x_inf      = x_exp_max & ~(|x[MAN_W-1:0]);
  assign y_inf      = y_exp_max & ~(|y[MAN_W-1:0]);
  assign is_special = x_exp_max | y_exp_max;

  always_comb begin
    byp_z        = FP_QNAN;
    byp_invalid  = 1'b0;
    byp_overflow = 1'b0;
    if (x_nan || y_nan) begin
      byp_invalid = 1'b1;
    end else if (x_inf && y_inf) begin
      if (eop) begin
        byp_invalid = 1'b1;
      end else begin
        byp_z        = x;
        byp_overflow = 1'b1;
      end
    end else if (x_inf) begin
      byp_z        = x;
      byp_overflow = 1'b1;
    end else if (y_inf) begin
      // y sign xor sub equals x sign xor eop, so eop alone carries the operation
      byp_z        = {x[31] ^ eop, y[30:0]};
      byp_overflow = 1'b1;
    end
  end

endmodule

// File: rtl/fp_add_ctrl.sv
// Sequences one operand pair through the fixed-latency FP adder core, bypassing NaN/inf; FP_ADD_CTRL_STICKY_EN enables sticky flags.
// Latency: core path LAT+2 cycles from input handshake to out_valid, special path 1 cycle.
// Single-entry: in_ready low while busy; result held stable until out_ready.
module fp_add_ctrl
  import fp_pkg::*;
#(
  parameter int LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  input  logic        in_sub,
  output logic        core_start,
  output logic [31:0] core_x,
  output logic [31:0] core_y,
  output logic        core_eop,
  input  logic [31:0] core_z,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_z,
  output logic        out_invalid,
  output logic        out_overflow,
  input  logic        clr_sticky,
  output logic        sticky_invalid,
  output logic        sticky_overflow
);

  localparam int CNT_W = $clog2(LAT + 1);

  ctrl_state_e      state_q, state_d;
  logic [31:0]      x_q, x_d;
  logic [31:0]      y_q, y_d;
  logic             eop_q, eop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      z_q, z_d;
  logic             inv_q, inv_d;
  logic             ovf_q, ovf_d;

  logic        in_eop;
  logic        x_nan, y_nan, x_inf, y_inf;
  logic        is_special;
  logic [31:0] byp_z;
  logic        byp_invalid, byp_overflow;
  logic        unused_class;
  logic        out_hs;

  assign in_eop       = in_x[31] ^ in_y[31] ^ in_sub;
  assign unused_class = x_nan ^ y_nan ^ x_inf ^ y_inf;

  fp_special_detect u_detect (
    .x            (in_x),
    .y            (in_y),
    .eop          (in_eop),
    .x_nan        (x_nan),
    .y_nan        (y_nan),
    .x_inf        (x_inf),
    .y_inf        (y_inf),
    .is_special   (is_special),
    .byp_z        (byp_z),
    .byp_invalid  (byp_invalid),
    .byp_overflow (byp_overflow)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    eop_d   = eop_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    inv_d   = inv_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d   = in_x;
          y_d   = in_y;
          eop_d = in_eop;
          if (is_special) begin
            z_d     = byp_z;
            inv_d   = byp_invalid;
            ovf_d   = byp_overflow;
            state_d = HOLD;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        // counter reaching zero on this decrement marks the cycle core_z is valid
        if (cnt_q == CNT_W'(1)) begin
          z_d     = core_z;
          inv_d   = 1'b0;
          ovf_d   = &core_z[30:23];
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      eop_q   <= 1'b0;
      cnt_q   <= '0;
      z_q     <= '0;
      inv_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      eop_q   <= eop_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      inv_q   <= inv_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready     = rst_n & (state_q == IDLE);
  assign core_start   = (state_q == ISSUE);
  assign core_x       = x_q;
  assign core_y       = y_q;
  assign core_eop     = eop_q;
  assign out_valid    = (state_q == HOLD);
  assign out_z        = z_q;
  assign out_invalid  = inv_q;
  assign out_overflow = ovf_q;
  assign out_hs       = out_valid & out_ready;

`ifdef FP_ADD_CTRL_STICKY_EN
  logic sinv_q, sinv_d;
  logic sovf_q, sovf_d;

  // a clear coincident with a handshake still lets the new result's flags through
  always_comb begin
    sinv_d = sinv_q;
    sovf_d = sovf_q;
    if (out_hs) begin
      sinv_d = (clr_sticky ? 1'b0 : sinv_q) | inv_q;
      sovf_d = (clr_sticky ? 1'b0 : sovf_q) | ovf_q;
    end else if (clr_sticky) begin
      sinv_d = 1'b0;
      sovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sinv_q <= 1'b0;
      sovf_q <= 1'b0;
    end else begin
      sinv_q <= sinv_d;
      sovf_q <= sovf_d;
    end
  end

  assign sticky_invalid  = sinv_q;
  assign sticky_overflow = sovf_q;
`else
  logic unused_sticky;
  assign unused_sticky   = clr_sticky ^ out_hs;
  assign sticky_invalid  = 1'b0;
  assign sticky_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_fp_add_ctrl.sv
// Directed-vector bench for fp_add_ctrl with a result scoreboard, a core model and a sticky-flag model.
module tb_fp_add_ctrl;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic        in_sub;
  logic        core_start;
  logic [31:0] core_x;
  logic [31:0] core_y;
  logic        core_eop;
  logic [31:0] core_z;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic        out_invalid;
  logic        out_overflow;
  logic        clr_sticky;
  logic        sticky_invalid;
  logic        sticky_overflow;

  always #5 clk = ~clk;

  fp_add_ctrl #(.LAT(LAT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_x            (in_x),
    .in_y            (in_y),
    .in_sub          (in_sub),
    .core_start      (core_start),
    .core_x          (core_x),
    .core_y          (core_y),
    .core_eop        (core_eop),
    .core_z          (core_z),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_z           (out_z),
    .out_invalid     (out_invalid),
    .out_overflow    (out_overflow),
    .clr_sticky      (clr_sticky),
    .sticky_invalid  (sticky_invalid),
    .sticky_overflow (sticky_overflow)
  );

  typedef struct {
    logic [31:0] z;
    logic        inv;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          n_start = 0;
  logic [31:0] nxt_cz;
  logic [31:0] e_cx;
  logic [31:0] e_cy;
  logic        e_eop;
  logic        m_si = 1'b0;
  logic        m_so = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Core model: returns nxt_cz exactly LAT cycles after core_start, garbage otherwise.
  initial begin
    logic [31:0] cz;
    core_z = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      if (core_start === 1'b1) begin
        n_start++;
        chk("core_x", core_x, e_cx);
        chk("core_y", core_y, e_cy);
        chk("core_eop", {31'b0, core_eop}, {31'b0, e_eop});
        cz = nxt_cz;
        repeat (LAT) @(posedge clk);
        #1 core_z = cz;
        @(posedge clk);
        #1 core_z = 32'hDEADBEEF;
      end
    end
  end

  // Monitor: pops the scoreboard at every output handshake and tracks sticky state.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got unexpected result %h, expected none", out_z);
        end else begin
          e = sb.pop_front();
          chk("out_z", out_z, e.z);
          chk("out_invalid", {31'b0, out_invalid}, {31'b0, e.inv});
          chk("out_overflow", {31'b0, out_overflow}, {31'b0, e.ovf});
`ifdef FP_ADD_CTRL_STICKY_EN
          m_si = (clr_sticky ? 1'b0 : m_si) | e.inv;
          m_so = (clr_sticky ? 1'b0 : m_so) | e.ovf;
`endif
        end
      end else if (rst_n === 1'b1 && clr_sticky === 1'b1) begin
`ifdef FP_ADD_CTRL_STICKY_EN
        m_si = 1'b0;
        m_so = 1'b0;
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic check_reset_vals();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_z", out_z, 32'd0);
    chk("rst_flags", {30'b0, out_invalid, out_overflow}, 32'd0);
    chk("rst_core_start", {31'b0, core_start}, 32'd0);
    chk("rst_core_x", core_x, 32'd0);
    chk("rst_core_y", core_y, 32'd0);
    chk("rst_core_eop", {31'b0, core_eop}, 32'd0);
    chk("rst_sticky", {30'b0, sticky_invalid, sticky_overflow}, 32'd0);
  endtask

  task automatic check_sticky(input string nm);
    chk(nm, {30'b0, sticky_invalid, sticky_overflow}, {30'b0, m_si, m_so});
  endtask

  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic sub,
                       input logic [31:0] cz, input logic [31:0] ez, input logic einv,
                       input logic eovf, input int elat, input int stall, input logic clr);
    exp_t e;
    int   n;
    int   s0;
    wait_ready();
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_sub   = sub;
    e_cx     = x;
    e_cy     = y;
    e_eop    = x[31] ^ y[31] ^ sub;
    nxt_cz   = cz;
    if (stall > 0 || clr) out_ready = 1'b0;
    e.z   = ez;
    e.inv = einv;
    e.ovf = eovf;
    sb.push_back(e);
    s0 = n_start;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_x     = 32'hFFFFFFFF;
    in_y     = 32'hFFFFFFFF;
    n = 1;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, elat);
    if (stall > 0 || clr) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("stall_out_z", out_z, ez);
        chk("stall_valid", {31'b0, out_valid}, 32'd1);
        chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      out_ready  = 1'b1;
      clr_sticky = clr;
      @(posedge clk);
      #1;
      clr_sticky = 1'b0;
    end
    @(negedge clk);
    chk("valid_drop", {31'b0, out_valid}, 32'd0);
    chk("ready_after", {31'b0, in_ready}, 32'd1);
    chk("core_starts", n_start - s0, (elat == 1) ? 32'd0 : 32'd1);
  endtask

  initial begin
    int s0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_x       = '0;
    in_y       = '0;
    in_sub     = 1'b0;
    out_ready  = 1'b1;
    clr_sticky = 1'b0;
    nxt_cz     = '0;
    e_cx       = '0;
    e_cy       = '0;
    e_eop      = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // finite add through the core
    do_op(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 32'h40400000, 1'b0, 1'b0, LAT + 2, 0, 1'b0);
    check_sticky("sticky_after_add");
    // NaN bypass
    do_op(32'h7FC00001, 32'h3F800000, 1'b0, 32'h0, 32'h7FC00000, 1'b1, 1'b0, 1, 0, 1'b0);
    check_sticky("sticky_after_nan");
    // clear alone
    @(posedge clk);
    #1 clr_sticky = 1'b1;
    @(posedge clk);
    #1 clr_sticky = 1'b0;
    @(negedge clk);
    check_sticky("sticky_after_clr");
    // inf - inf
    do_op(32'h7F800000, 32'h7F800000, 1'b1, 32'h0, 32'h7FC00000, 1'b1, 1'b0, 1, 0, 1'b0);
    check_sticky("sticky_inf_sub");
    // inf + inf with clear on the same handshake
    do_op(32'h7F800000, 32'h7F800000, 1'b0, 32'h0, 32'h7F800000, 1'b0, 1'b1, 1, 0, 1'b1);
    check_sticky("sticky_clr_coincident");
    // only y infinite, subtract flips its sign
    do_op(32'h3F800000, 32'h7F800000, 1'b1, 32'h0, 32'hFF800000, 1'b0, 1'b1, 1, 0, 1'b0);
    // opposite-sign infinities under add are an effective subtraction
    do_op(32'hFF800000, 32'h7F800000, 1'b0, 32'h0, 32'h7FC00000, 1'b1, 1'b0, 1, 0, 1'b0);
    // y NaN
    do_op(32'h3F800000, 32'hFF800001, 1'b0, 32'h0, 32'h7FC00000, 1'b1, 1'b0, 1, 0, 1'b0);
    check_sticky("sticky_accum");
    // core overflow with a 4-cycle stall
    do_op(32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 32'h7F800000, 1'b0, 1'b1, LAT + 2, 4, 1'b0);
    check_sticky("sticky_core_ovf");

    // reset while waiting on the core
    wait_ready();
    in_valid = 1'b1;
    in_x     = 32'h3F800000;
    in_y     = 32'h3F800000;
    in_sub   = 1'b0;
    e_cx     = 32'h3F800000;
    e_cy     = 32'h3F800000;
    e_eop    = 1'b0;
    nxt_cz   = 32'h40000000;
    s0       = n_start;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals();
    m_si  = 1'b0;
    m_so  = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
      chk("post_rst_start", {31'b0, core_start}, 32'd0);
    end
    chk("rst_core_starts", n_start - s0, 32'd1);

    // normal operation resumes: finite subtraction
    do_op(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 32'h40000000, 1'b0, 1'b0, LAT + 2, 0, 1'b0);
    check_sticky("sticky_after_rst");

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
